// File: rtl/mq_emit_pkg.sv
// Shared types and constants for the MQ coder byte emitter.
package mq_emit_pkg;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam int         MAX_IN_BYTES = 2;
  localparam logic [7:0] FF_BYTE      = 8'hFF;

endpackage

// File: rtl/mq_byte_emitter_if.sv
// Coder-side beat input and consumer-side byte stream of the MQ byte emitter.
interface mq_byte_emitter_if;

  logic        in_valid;
  logic [15:0] in_bytes;
  logic [1:0]  in_cnt;
  logic        in_flush;
  logic        in_ready;
  logic        out_valid;
  logic [7:0]  out_byte;
  logic        out_last;
  logic        out_ready;

  modport master (
    output in_valid, in_bytes, in_cnt, in_flush, out_ready,
    input  in_ready, out_valid, out_byte, out_last
  );

  modport slave (
    input  in_valid, in_bytes, in_cnt, in_flush, out_ready,
    output in_ready, out_valid, out_byte, out_last
  );

endinterface

// File: rtl/mq_byte_fifo.sv
// Show-ahead byte FIFO: up to two writes and one read per cycle, plus a
// retract that removes the most recently written byte.
module mq_byte_fifo #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    push_cnt_i,
  input  logic [7:0]    push_a_i,
  input  logic [7:0]    push_b_i,
  input  logic          pop_i,
  input  logic          retract_i,
  output logic [AW:0]   occ_o,
  output logic [7:0]    head_o,
  output logic [7:0]    tail_o
);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d, wr_nxt, tail_idx;
  logic [AW:0]   occ_q, occ_d;

  // Outputs come straight from registers so they never depend on this cycle's push.
  assign wr_nxt   = wr_q + AW'(1);
  assign tail_idx = wr_q - AW'(1);
  assign occ_o    = occ_q;
  assign head_o   = mem_q[rd_q];
  assign tail_o   = mem_q[tail_idx];

  always_comb begin
    rd_d  = rd_q + AW'(pop_i);
    wr_d  = wr_q + AW'(push_cnt_i) - AW'(retract_i);
    occ_d = occ_q + (AW+1)'(push_cnt_i) - (AW+1)'(pop_i) - (AW+1)'(retract_i);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_cnt_i != 2'd0) mem_q[wr_q]   <= push_a_i;
    if (push_cnt_i == 2'd2) mem_q[wr_nxt] <= push_b_i;
  end

endmodule

// File: rtl/mq_byte_emitter.sv
// MQ coder output controller: buffers coder bytes, streams them out and
// marks segment ends. Optional MQ_TRAIL_FF_DROP_EN drops a trailing 0xFF.
module mq_byte_emitter
  import mq_emit_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  mq_byte_emitter_if.slave bus,
  output logic             done,
  output logic [15:0]      byte_count,
  output logic             err
);

`ifdef MQ_TRAIL_FF_DROP_EN
  localparam bit DROP_EN = 1'b1;
`else
  localparam bit DROP_EN = 1'b0;
`endif

  state_e        state_q, state_d;
  logic [AW:0]   occ;
  logic [7:0]    head, tail, push_a;
  logic [1:0]    push_cnt;
  logic [AW+1:0] free;
  logic          accept, pop, retract, beat_drop;
  logic          drop_pend_q, drop_pend_d;
  logic [15:0]   byte_count_q;
  logic          err_q;

  mq_byte_fifo #(.DEPTH(DEPTH), .AW(AW)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push_cnt_i (push_cnt),
    .push_a_i   (push_a),
    .push_b_i   (bus.in_bytes[7:0]),
    .pop_i      (pop),
    .retract_i  (retract),
    .occ_o      (occ),
    .head_o     (head),
    .tail_o     (tail)
  );

  // A flush beat with no bytes can only drop 0xFF already sitting at the FIFO tail.
  always_comb begin
    retract   = DROP_EN && drop_pend_q && (occ != '0) && (tail == FF_BYTE);
    beat_drop = DROP_EN && bus.in_flush &&
                ((bus.in_cnt == 2'd1) || (bus.in_cnt == 2'd2)) &&
                (bus.in_bytes[7:0] == FF_BYTE);
    push_a    = (bus.in_cnt == 2'd2) ? bus.in_bytes[15:8] : bus.in_bytes[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= RUN;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (accept && bus.in_flush) state_d = FLUSH;
      FLUSH:   if ((occ == '0) || ((occ == (AW+1)'(1)) && (pop || retract))) state_d = DONE;
      DONE:    state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Ordered so in_ready sees the same-cycle pop without a combinational loop.
  always_comb begin
    bus.out_valid = !rst && (occ != '0) && (state_q != DONE) && !retract;
    bus.out_byte  = head;
    bus.out_last  = bus.out_valid && (state_q == FLUSH) && (occ == (AW+1)'(1));
    pop           = bus.out_valid && bus.out_ready;
    free          = (AW+2)'(DEPTH) - (AW+2)'(occ) + (AW+2)'(pop);
    bus.in_ready  = !rst && (state_q == RUN) && (free >= (AW+2)'(MAX_IN_BYTES));
    accept        = bus.in_valid && bus.in_ready;
    done          = !rst && (state_q == DONE);
    push_cnt      = 2'd0;
    if (accept) begin
      case (bus.in_cnt)
        2'd1:    push_cnt = beat_drop ? 2'd0 : 2'd1;
        2'd2:    push_cnt = beat_drop ? 2'd1 : 2'd2;
        default: push_cnt = 2'd0;
      endcase
    end
    drop_pend_d = accept && bus.in_flush &&
                  ((bus.in_cnt == 2'd0) || (bus.in_cnt == 2'd3));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_count_q <= '0;
      err_q        <= 1'b0;
      drop_pend_q  <= 1'b0;
    end else begin
      if (pop) byte_count_q <= byte_count_q + 16'd1;
      if (accept && (bus.in_cnt == 2'd3)) err_q <= 1'b1;
      drop_pend_q <= drop_pend_d;
    end
  end

  assign byte_count = byte_count_q;
  assign err        = err_q;

endmodule
